micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
//  Next-microaddress controller for the multicycle RISC-V microprogrammed core.
//  Holds the micro-PC (uaddr) that indexes the external control store, and applies the
//  microword's sequencing field and opcode dispatch to it. Stalls on memory wait states,
//  traps on illegal opcodes, illegal seq codes and bus timeouts, and supports a halt microop.
// PARAMETERS
//  UADDR_W    4     micro-PC width (control store depth 2**UADDR_W)
//  FETCH_ADDR 4'h0  fetch microaddress (reset target, seq=011)
//  JUMP_ADDR  4'h7  fixed jump target (seq=100)
//  TRAP_ADDR  4'hF  trap handler microaddress
//  MAX_WAIT   15    WAIT-state cycles allowed before bus timeout (1..255)
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        synchronous, active-high reset
//  op          in   7        opcode of latched instruction (IR[6:0])
//  seq         in   3        sequencing field of current microword
//  mem_req     in   1        current microword accesses memory
//  mem_ready   in   1        memory completes access this cycle
//  uaddr       out  UADDR_W  registered micro-PC to control store
//  stall       out  1        comb: datapath must hold all register write enables
//  trap        out  1        registered 1-cycle pulse, trap taken
//  trap_cause  out  2        01 illegal op, 10 illegal seq, 11 bus timeout; held until next trap
//  halted      out  1        sequencer in HALT
//  stall_cnt   out  32       stalled-cycle count (USEQ_PERF_EN)
//  instr_cnt   out  32       retired-instruction count (USEQ_PERF_EN)
// BEHAVIOUR
//  Reset: uaddr=FETCH_ADDR, state=RUN, trap=0, trap_cause=00, halted=0, wait_cnt=0, counters=0.
//  Dispatch 1: R 0110011->6, I 0010011->8, J 1101111->9, B 1100011->A, lw 0000011->2, sw 0100011->2.
//  Dispatch 2: lw->3, sw->5. Any other op misses that table.
//  seq: 000 uaddr+1 (wraps mod 2**UADDR_W); 001 disp1; 010 disp2; 011 FETCH_ADDR;
//   100 JUMP_ADDR; 101 halt; 110/111 illegal seq.
//  States RUN, WAIT, HALT. All updates on the posedge.
//  RUN, mem_req=1 & mem_ready=0: stall=1, uaddr held, ->WAIT, wait_cnt=1.
//  RUN, otherwise: apply seq next cycle (1-cycle latency). Dispatch miss or illegal seq:
//   uaddr<=TRAP_ADDR, trap pulse, cause 01/10. seq=101: ->HALT, uaddr held.
//  WAIT: stall=!mem_ready. mem_ready=1 applies seq as in RUN, ->RUN, wait_cnt=0.
//   mem_ready=0 & wait_cnt==MAX_WAIT: trap, cause 11, uaddr<=TRAP_ADDR, ->RUN. Else wait_cnt++.
//   So stall is high for MAX_WAIT+1 cycles before a timeout.
//  mem_ready and timeout in the same cycle: ready wins, no trap.
//  Stall takes priority over seq; halt and trap are applied only on the unstalled cycle.
//  HALT: uaddr held, stall=1, halted=1; rst is the only exit. mem_req/op ignored.
//  Trap at TRAP_ADDR is a normal microaddress: the handler's seq field sequences it.
//  Reset mid-WAIT or mid-HALT: same as power-on reset, no trap pulse.
// CONFIGURATION
//  USEQ_PERF_EN defined: stall_cnt++ each cycle stall=1 (HALT excluded).
//   instr_cnt++ on each unstalled seq=011 taken. Both counters wrap at 2**32.
//  USEQ_PERF_EN undefined: both ports present, tied to 32'h0, no counter flops.
// TESTING
//  1 rst 2 cycles, op=0110011, seq 000 then 001 -> uaddr 0,1,6; trap=0.
//  2 lw: uaddr 1 seq=001 ->2; seq=010 ->3; seq=000 ->4; seq=011 ->0; instr_cnt=1 (PERF).
//  3 mem_req=1, mem_ready low 3 cycles then high, seq=000 at uaddr 4 ->
//    stall=1 for 3 cycles, uaddr 4 held, then 5; stall_cnt=3.
//  4 mem_req=1, mem_ready=0 forever, MAX_WAIT=15 -> stall 16 cycles, trap pulse,
//    trap_cause=11, uaddr=F.
//  5 op=1110011 with seq=001, then seq=110 -> trap cause 01, uaddr=F; then cause 10;
//    ready+timeout same cycle -> no trap.
//  6 seq=101 -> halted=1, uaddr held 10 cycles; rst -> uaddr=0, halted=0, trap_cause=00.

Source files
------------

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - next-microaddress controller for the microprogrammed RISC-V core
//
// Holds the micro-PC that indexes the external control store and advances it from the
// current microword's seq field, with two opcode dispatch tables, memory wait-state
// stalls, bus timeout, trap redirection and a terminal HALT state.
//
// Optional feature macro: USEQ_PERF_EN (stall / retired-instruction counters).
//
// Ports:
//   clk         in   1        clock, rising edge
//   rst         in   1        synchronous active-high reset
//   op          in   7        opcode of latched instruction
//   seq         in   3        sequencing field of current microword
//   mem_req     in   1        current microword accesses memory
//   mem_ready   in   1        memory completes the access this cycle
//   uaddr       out  UADDR_W  registered micro-PC
//   stall       out  1        combinational hold for all datapath write enables
//   trap        out  1        one-cycle pulse, trap taken
//   trap_cause  out  2        01 illegal op, 10 illegal seq, 11 bus timeout
//   halted      out  1        sequencer is in HALT
//   stall_cnt   out  32       stalled-cycle count (zero without USEQ_PERF_EN)
//   instr_cnt   out  32       retired-instruction count (zero without USEQ_PERF_EN)
module micro_sequencer #(
  parameter int                   UADDR_W    = 4,
  parameter logic [UADDR_W-1:0]   FETCH_ADDR = 4'h0,
  parameter logic [UADDR_W-1:0]   JUMP_ADDR  = 4'h7,
  parameter logic [UADDR_W-1:0]   TRAP_ADDR  = 4'hF,
  parameter int                   MAX_WAIT   = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         seq,
  input  logic               mem_req,
  input  logic               mem_ready,
  output logic [UADDR_W-1:0] uaddr,
  output logic               stall,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic               halted,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        instr_cnt
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_e;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_e             state_q, state_d;
  logic [UADDR_W-1:0] uaddr_q, uaddr_d;
  logic [7:0]         wait_q, wait_d;
  logic               trap_q, trap_d;
  logic [1:0]         cause_q, cause_d;

  // Result of applying seq to the current micro-PC, independent of the FSM state.
  logic [UADDR_W-1:0] seq_ua;
  logic               seq_trap;
  logic [1:0]         seq_cause;
  logic               seq_halt;
  logic               apply;

  logic               d1_hit, d2_hit;
  logic [UADDR_W-1:0] d1_ua, d2_ua;

  always_comb begin
    d1_hit = 1'b1;
    d1_ua  = '0;
    case (op)
      7'b0110011: d1_ua = UADDR_W'(6);
      7'b0010011: d1_ua = UADDR_W'(8);
      7'b1101111: d1_ua = UADDR_W'(9);
      7'b1100011: d1_ua = UADDR_W'(10);
      7'b0000011: d1_ua = UADDR_W'(2);
      7'b0100011: d1_ua = UADDR_W'(2);
      default:    d1_hit = 1'b0;
    endcase
  end

  always_comb begin
    d2_hit = 1'b1;
    d2_ua  = '0;
    case (op)
      7'b0000011: d2_ua = UADDR_W'(3);
      7'b0100011: d2_ua = UADDR_W'(5);
      default:    d2_hit = 1'b0;
    endcase
  end

  always_comb begin
    seq_ua    = uaddr_q;
    seq_trap  = 1'b0;
    seq_cause = 2'b00;
    seq_halt  = 1'b0;
    case (seq)
      3'b000: seq_ua = uaddr_q + 1'b1;
      3'b001: begin
        seq_ua    = d1_ua;
        seq_trap  = !d1_hit;
        seq_cause = 2'b01;
      end
      3'b010: begin
        seq_ua    = d2_ua;
        seq_trap  = !d2_hit;
        seq_cause = 2'b01;
      end
      3'b011: seq_ua = FETCH_ADDR;
      3'b100: seq_ua = JUMP_ADDR;
      3'b101: seq_halt = 1'b1;
      default: begin
        seq_trap  = 1'b1;
        seq_cause = 2'b10;
      end
    endcase
    if (seq_trap) seq_ua = TRAP_ADDR;
  end

  always_comb begin
    state_d = state_q;
    uaddr_d = uaddr_q;
    wait_d  = wait_q;
    trap_d  = 1'b0;
    cause_d = cause_q;
    stall   = 1'b0;
    apply   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (mem_req && !mem_ready) begin
          stall   = 1'b1;
          state_d = S_WAIT;
          wait_d  = 8'd1;
        end else begin
          apply = 1'b1;
        end
      end
      S_WAIT: begin
        stall = !mem_ready;
        // Ready is checked first so a completion on the timeout cycle never traps.
        if (mem_ready) begin
          apply = 1'b1;
        end else if (wait_q == MAX_WAIT_C) begin
          trap_d  = 1'b1;
          cause_d = 2'b11;
          uaddr_d = TRAP_ADDR;
          state_d = S_RUN;
          wait_d  = 8'd0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_HALT: stall = 1'b1;
      default: state_d = S_RUN;
    endcase
    if (apply) begin
      wait_d  = 8'd0;
      state_d = seq_halt ? S_HALT : S_RUN;
      uaddr_d = seq_halt ? uaddr_q : seq_ua;
      trap_d  = seq_trap;
      if (seq_trap) cause_d = seq_cause;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      uaddr_q <= FETCH_ADDR;
      wait_q  <= 8'd0;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      uaddr_q <= uaddr_d;
      wait_q  <= wait_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  assign uaddr      = uaddr_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign halted     = (state_q == S_HALT);

`ifdef USEQ_PERF_EN
  logic [31:0] stall_cnt_q, instr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      if (stall && state_q != S_HALT) stall_cnt_q <= stall_cnt_q + 32'd1;
      // A retired instruction is an unstalled return to fetch.
      if (apply && seq == 3'b011) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  assign stall_cnt = 32'h0;
  assign instr_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - self-checking bench for micro_sequencer
module tb_micro_sequencer;
  localparam int MW = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  op = 7'd0;
  logic [2:0]  seq = 3'd0;
  logic        mem_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic [3:0]  uaddr;
  logic        stall, trap, halted;
  logic [1:0]  trap_cause;
  logic [31:0] stall_cnt, instr_cnt;

  micro_sequencer dut (
    .clk(clk), .rst(rst), .op(op), .seq(seq), .mem_req(mem_req), .mem_ready(mem_ready),
    .uaddr(uaddr), .stall(stall), .trap(trap), .trap_cause(trap_cause), .halted(halted),
    .stall_cnt(stall_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 running, 1 waiting on memory, 2 halted.
  int          m_ua, m_mode, m_wc;
  logic [1:0]  m_cause;
  bit          m_trap, m_valid = 0;
  logic [31:0] m_sc, m_ic;

  function automatic int dispatch(input int tbl, input logic [6:0] o);
    if (tbl == 1) begin
      if (o == 7'b0110011) return 6;
      if (o == 7'b0010011) return 8;
      if (o == 7'b1101111) return 9;
      if (o == 7'b1100011) return 10;
      if (o == 7'b0000011 || o == 7'b0100011) return 2;
    end else begin
      if (o == 7'b0000011) return 3;
      if (o == 7'b0100011) return 5;
    end
    return -1;
  endfunction

  function automatic bit exp_stall();
    if (m_mode == 2) return 1'b1;
    if (m_mode == 1) return !mem_ready;
    return mem_req && !mem_ready;
  endfunction

  task automatic take_trap(input int c);
    m_trap  = 1'b1;
    m_cause = 2'(c);
    m_ua    = 15;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_ua = 0; m_mode = 0; m_wc = 0; m_cause = 2'b00; m_trap = 1'b0;
      m_sc = 32'd0; m_ic = 32'd0; m_valid = 1;
    end else if (m_valid) begin
      bit st;
      int t;
      st = exp_stall();
      m_trap = 1'b0;
      if (m_mode != 2) begin
        if (st) m_sc = m_sc + 32'd1;
        if (m_mode == 0 && st) begin
          m_mode = 1; m_wc = 1;
        end else if (m_mode == 1 && !mem_ready) begin
          if (m_wc == MW) begin take_trap(3); m_mode = 0; m_wc = 0; end
          else m_wc++;
        end else begin
          m_mode = 0; m_wc = 0;
          case (seq)
            3'd0: m_ua = (m_ua + 1) % 16;
            3'd1, 3'd2: begin
              t = dispatch(int'(seq), op);
              if (t < 0) take_trap(1); else m_ua = t;
            end
            3'd3: begin m_ua = 0; m_ic = m_ic + 32'd1; end
            3'd4: m_ua = 7;
            3'd5: m_mode = 2;
            default: take_trap(2);
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("uaddr", 32'(uaddr), m_ua);
      chk("stall", 32'(stall), 32'(exp_stall()));
      chk("trap", 32'(trap), 32'(m_trap));
      chk("trap_cause", 32'(trap_cause), 32'(m_cause));
      chk("halted", 32'(halted), 32'(m_mode == 2));
`ifdef USEQ_PERF_EN
      chk("stall_cnt", stall_cnt, m_sc);
      chk("instr_cnt", instr_cnt, m_ic);
`else
      chk("stall_cnt_tied", stall_cnt, 32'h0);
      chk("instr_cnt_tied", instr_cnt, 32'h0);
`endif
    end
  end

  task automatic set(input logic [6:0] o, input logic [2:0] s, input logic rq, input logic rd);
    op = o; seq = s; mem_req = rq; mem_ready = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [6:0] o, input logic [2:0] s, input logic rq, input logic rd);
    set(o, s, rq, rd);
    tick();
  endtask

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_BAD = 7'b1110011;

  initial begin
    // reset for two cycles
    rst = 1'b1;
    step(OP_R, 3'b000, 1'b0, 1'b0);
    step(OP_R, 3'b000, 1'b0, 1'b0);
    chk("rst_uaddr", 32'(uaddr), 32'h0);
    chk("rst_trap", 32'(trap), 32'h0);
    chk("rst_cause", 32'(trap_cause), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    rst = 1'b0;

    // increment then R-type dispatch
    step(OP_R, 3'b000, 1'b0, 1'b0);
    chk("t1_inc", 32'(uaddr), 32'h1);
    step(OP_R, 3'b001, 1'b0, 1'b0);
    chk("t1_disp_r", 32'(uaddr), 32'h6);
    chk("t1_trap", 32'(trap), 32'h0);
    step(OP_I, 3'b001, 1'b0, 1'b0);
    chk("disp_i", 32'(uaddr), 32'h8);
    step(OP_J, 3'b001, 1'b0, 1'b0);
    chk("disp_j", 32'(uaddr), 32'h9);
    step(OP_B, 3'b001, 1'b0, 1'b0);
    chk("disp_b", 32'(uaddr), 32'hA);
    step(OP_B, 3'b100, 1'b0, 1'b0);
    chk("jump", 32'(uaddr), 32'h7);

    // lw through both dispatch tables and back to fetch
    rst = 1'b1;
    step(OP_LW, 3'b000, 1'b0, 1'b0);
    rst = 1'b0;
    step(OP_LW, 3'b000, 1'b0, 1'b0);
    step(OP_LW, 3'b001, 1'b0, 1'b0);
    chk("t2_disp1", 32'(uaddr), 32'h2);
    step(OP_LW, 3'b010, 1'b0, 1'b0);
    chk("t2_disp2", 32'(uaddr), 32'h3);
    step(OP_LW, 3'b000, 1'b0, 1'b0);
    chk("t2_inc", 32'(uaddr), 32'h4);
    step(OP_LW, 3'b011, 1'b0, 1'b0);
    chk("t2_fetch", 32'(uaddr), 32'h0);
`ifdef USEQ_PERF_EN
    chk("t2_instr_cnt", instr_cnt, 32'd1);
`endif
    for (int i = 0; i < 4; i++) step(OP_LW, 3'b000, 1'b0, 1'b0);
    chk("t3_start", 32'(uaddr), 32'h4);

    // three wait states then ready
    for (int i = 0; i < 3; i++) begin
      set(OP_LW, 3'b000, 1'b1, 1'b0);
      #1;
      chk("t3_stall", 32'(stall), 32'h1);
      chk("t3_hold", 32'(uaddr), 32'h4);
      tick();
    end
    set(OP_LW, 3'b000, 1'b1, 1'b1);
    #1;
    chk("t3_release", 32'(stall), 32'h0);
    tick();
    chk("t3_next", 32'(uaddr), 32'h5);
`ifdef USEQ_PERF_EN
    chk("t3_stall_cnt", stall_cnt, 32'd3);
`endif

    // bus timeout after MAX_WAIT+1 stalled cycles
    for (int i = 0; i < MW + 1; i++) begin
      set(OP_LW, 3'b000, 1'b1, 1'b0);
      #1;
      chk("t4_stall", 32'(stall), 32'h1);
      tick();
      if (i < MW) chk("t4_no_early_trap", 32'(trap), 32'h0);
    end
    chk("t4_trap", 32'(trap), 32'h1);
    chk("t4_cause", 32'(trap_cause), 32'h3);
    chk("t4_uaddr", 32'(uaddr), 32'hF);
    step(OP_LW, 3'b000, 1'b0, 1'b0);
    chk("t4_pulse_end", 32'(trap), 32'h0);
    chk("t4_wrap", 32'(uaddr), 32'h0);

    // illegal opcode, illegal seq, ready on the timeout cycle
    step(OP_BAD, 3'b001, 1'b0, 1'b0);
    chk("t5_op_trap", 32'(trap), 32'h1);
    chk("t5_op_cause", 32'(trap_cause), 32'h1);
    chk("t5_op_uaddr", 32'(uaddr), 32'hF);
    step(OP_R, 3'b110, 1'b0, 1'b0);
    chk("t5_seq_trap", 32'(trap), 32'h1);
    chk("t5_seq_cause", 32'(trap_cause), 32'h2);
    for (int i = 0; i < MW; i++) step(OP_R, 3'b000, 1'b1, 1'b0);
    step(OP_R, 3'b000, 1'b1, 1'b1);
    chk("t5_race_trap", 32'(trap), 32'h0);
    chk("t5_race_cause", 32'(trap_cause), 32'h2);
    chk("t5_race_uaddr", 32'(uaddr), 32'h0);

    // halt holds everything until reset
    step(OP_R, 3'b000, 1'b0, 1'b0);
    step(OP_R, 3'b101, 1'b0, 1'b0);
    chk("t6_halted", 32'(halted), 32'h1);
    for (int i = 0; i < 10; i++) begin
      step(7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      chk("t6_hold", 32'(uaddr), 32'h1);
      chk("t6_stall", 32'(stall), 32'h1);
    end
    rst = 1'b1;
    step(OP_R, 3'b000, 1'b0, 1'b0);
    rst = 1'b0;
    chk("t6_uaddr", 32'(uaddr), 32'h0);
    chk("t6_unhalt", 32'(halted), 32'h0);
    chk("t6_cause", 32'(trap_cause), 32'h0);

    // reset in the middle of a wait
    for (int i = 0; i < 3; i++) step(OP_R, 3'b000, 1'b1, 1'b0);
    rst = 1'b1;
    step(OP_R, 3'b000, 1'b1, 1'b0);
    rst = 1'b0;
    chk("rw_trap", 32'(trap), 32'h0);
    chk("rw_uaddr", 32'(uaddr), 32'h0);
    step(OP_R, 3'b000, 1'b0, 1'b0);
    chk("rw_run", 32'(uaddr), 32'h1);
    step(OP_R, 3'b000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
